// File: rtl/sysid_boot_arbiter_if.sv
// Avalon-style read bus between the external master and the sysid arbiter.
// master drives read/address; slave returns waitrequest, readdata, readdatavalid.
interface sysid_boot_arbiter_if;
  logic        m_read;
  logic        m_address;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  modport master (
    output m_read,
    output m_address,
    input  m_waitrequest,
    input  m_readdata,
    input  m_readdatavalid
  );

  modport slave (
    input  m_read,
    input  m_address,
    output m_waitrequest,
    output m_readdata,
    output m_readdatavalid
  );
endinterface

// File: rtl/sysid_boot_arbiter.sv
// Boot-time sysid check (ID + timestamp) with retries, then shares the sysid
// slave with one external read master.
// Ports: clock/reset, sys_address/sys_readdata to the sysid slave, m (bus slave
// side), recheck pulse, check_done/check_pass/check_fail/err_code status.
module sysid_boot_arbiter #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h5A98_7835,
  parameter int          RETRY_MAX   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 sys_address,
  input  logic [31:0]          sys_readdata,
  sysid_boot_arbiter_if.slave  m,
  input  logic                 recheck,
  output logic                 check_done,
  output logic                 check_pass,
  output logic                 check_fail,
  output logic [1:0]           err_code
);

  localparam int AW = $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {
    CHK_ID,
    CHK_TS,
    EVAL,
    READY
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] attempts;
  logic [31:0]   id_q;
  logic [31:0]   ts_q;
  logic          pass_q;
  logic          fail_q;
  logic          id_bad;
  logic          ts_bad;
  logic          last_try;
  logic          rerun;
  logic          accept;

  assign id_bad   = (id_q != EXPECTED_ID);
  assign ts_bad   = (ts_q != EXPECTED_TS);
  assign last_try = (32'(attempts) + 32'd1 >= 32'(RETRY_MAX));
  assign rerun    = (state == READY) & recheck;

  // recheck stalls the master so a rerun never races an accepted read
  assign m.m_waitrequest = (state != READY) | recheck;
  assign accept          = m.m_read & ~m.m_waitrequest;

  assign check_pass = pass_q;
  assign check_fail = fail_q;
  assign check_done = pass_q | fail_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CHK_ID;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    sys_address = 1'b0;
    unique case (state)
      CHK_ID: state_nx = CHK_TS;
      CHK_TS: begin
        sys_address = 1'b1;
        state_nx    = EVAL;
      end
      EVAL: begin
        if (!(id_bad || ts_bad) || last_try) state_nx = READY;
        else                                 state_nx = CHK_ID;
      end
      READY: begin
        sys_address = m.m_address;
        if (rerun) state_nx = CHK_ID;
      end
      default: state_nx = CHK_ID;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      attempts          <= '0;
      id_q              <= '0;
      ts_q              <= '0;
      pass_q            <= 1'b0;
      fail_q            <= 1'b0;
      err_code          <= 2'b00;
      m.m_readdata      <= '0;
      m.m_readdatavalid <= 1'b0;
    end else begin
      m.m_readdatavalid <= accept;
      if (accept) m.m_readdata <= sys_readdata;
      unique case (state)
        CHK_ID: id_q <= sys_readdata;
        CHK_TS: ts_q <= sys_readdata;
        EVAL: begin
          err_code <= {ts_bad, id_bad};
          if (!(id_bad || ts_bad)) pass_q   <= 1'b1;
          else if (last_try)       fail_q   <= 1'b1;
          else                     attempts <= attempts + 1'b1;
        end
        READY: begin
          if (rerun) begin
            attempts <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            err_code <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_arbiter.sv
// Directed bench for sysid_boot_arbiter: boot check, retries, failure,
// arbitrated reads, recheck and asynchronous reset.
module tb_sysid_boot_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sys_address;
  logic [31:0] sys_readdata;
  logic        recheck = 1'b0;
  logic        check_done;
  logic        check_pass;
  logic        check_fail;
  logic [1:0]  err_code;
  logic [31:0] id_val = 32'h0000_0000;
  logic [31:0] ts_val = 32'h5A98_7835;
  int          tests = 0;
  int          fails = 0;

  sysid_boot_arbiter_if bus ();

  sysid_boot_arbiter #(
    .EXPECTED_ID (32'h0000_0000),
    .EXPECTED_TS (32'h5A98_7835),
    .RETRY_MAX   (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sys_address  (sys_address),
    .sys_readdata (sys_readdata),
    .m            (bus.slave),
    .recheck      (recheck),
    .check_done   (check_done),
    .check_pass   (check_pass),
    .check_fail   (check_fail),
    .err_code     (err_code)
  );

  always #5 clock = ~clock;

  assign sys_readdata = sys_address ? ts_val : id_val;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.m_read    = 1'b0;
    bus.m_address = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_wait",  32'(bus.m_waitrequest), 32'd1);
    chk("rst_valid", 32'(bus.m_readdatavalid), 32'd0);
    chk("rst_data",  bus.m_readdata, 32'd0);
    chk("rst_done",  32'(check_done), 32'd0);
    chk("rst_err",   32'(err_code), 32'd0);

    // boot pass after 3 edges
    reset = 1'b0;
    tick();
    tick();
    chk("boot_done2", 32'(check_done), 32'd0);
    chk("boot_wait2", 32'(bus.m_waitrequest), 32'd1);
    tick();
    chk("boot_done", 32'(check_done), 32'd1);
    chk("boot_pass", 32'(check_pass), 32'd1);
    chk("boot_fail", 32'(check_fail), 32'd0);
    chk("boot_err",  32'(err_code), 32'd0);
    chk("boot_wait", 32'(bus.m_waitrequest), 32'd0);

    // back-to-back reads addr 1 then addr 0
    bus.m_read    = 1'b1;
    bus.m_address = 1'b1;
    #1;
    chk("rd_sysaddr", 32'(sys_address), 32'd1);
    tick();
    bus.m_address = 1'b0;
    chk("rd1_valid", 32'(bus.m_readdatavalid), 32'd1);
    chk("rd1_data",  bus.m_readdata, 32'h5A98_7835);
    tick();
    bus.m_read = 1'b0;
    chk("rd2_valid", 32'(bus.m_readdatavalid), 32'd1);
    chk("rd2_data",  bus.m_readdata, 32'h0000_0000);
    tick();
    chk("rd3_valid", 32'(bus.m_readdatavalid), 32'd0);

    // recheck wins over a same-cycle read
    bus.m_read    = 1'b1;
    bus.m_address = 1'b1;
    recheck       = 1'b1;
    #1;
    chk("rc_wait", 32'(bus.m_waitrequest), 32'd1);
    tick();
    recheck = 1'b0;
    chk("rc_valid", 32'(bus.m_readdatavalid), 32'd0);
    chk("rc_done",  32'(check_done), 32'd0);
    chk("rc_wait2", 32'(bus.m_waitrequest), 32'd1);
    chk("rc_sysaddr", 32'(sys_address), 32'd0);
    tick();
    tick();
    chk("rc_busy", 32'(check_done), 32'd0);
    tick();
    chk("rc_redone", 32'(check_pass), 32'd1);
    chk("rc_nvalid", 32'(bus.m_readdatavalid), 32'd0);
    tick();
    bus.m_read = 1'b0;
    chk("rc_rvalid", 32'(bus.m_readdatavalid), 32'd1);
    chk("rc_rdata",  bus.m_readdata, 32'h5A98_7835);

    // TS mismatch: fail after 9 edges
    ts_val = 32'h1234_5678;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("tf_done8", 32'(check_done), 32'd0);
    tick();
    chk("tf_done", 32'(check_done), 32'd1);
    chk("tf_fail", 32'(check_fail), 32'd1);
    chk("tf_pass", 32'(check_pass), 32'd0);
    chk("tf_err",  32'(err_code), 32'd2);
    bus.m_read    = 1'b1;
    bus.m_address = 1'b1;
    tick();
    bus.m_read = 1'b0;
    chk("tf_rvalid", 32'(bus.m_readdatavalid), 32'd1);
    chk("tf_rdata",  bus.m_readdata, 32'h1234_5678);

    // ID bad on first attempt only: pass after 6 edges
    ts_val = 32'h5A98_7835;
    id_val = 32'hDEAD_BEEF;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    id_val = 32'h0000_0000;
    for (int i = 0; i < 4; i++) tick();
    chk("ir_done5", 32'(check_done), 32'd0);
    tick();
    chk("ir_pass", 32'(check_pass), 32'd1);
    chk("ir_err",  32'(err_code), 32'd0);

    // reset asserted during CHK_TS
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rt_wait", 32'(bus.m_waitrequest), 32'd1);
    chk("rt_done", 32'(check_done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rt_pass", 32'(check_pass), 32'd1);

    // reset asserted with a read in flight
    bus.m_read    = 1'b1;
    bus.m_address = 1'b1;
    tick();
    chk("rr_valid", 32'(bus.m_readdatavalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rr_valid0", 32'(bus.m_readdatavalid), 32'd0);
    chk("rr_data0",  bus.m_readdata, 32'd0);
    chk("rr_pass0",  32'(check_pass), 32'd0);
    tick();
    chk("rr_valid1", 32'(bus.m_readdatavalid), 32'd0);
    bus.m_read = 1'b0;
    reset      = 1'b0;
    tick();
    tick();
    tick();
    chk("rr_pass", 32'(check_pass), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
